// File: rtl/axi4_lite_register_slave.sv
// AXI4-Lite slave exposing REG_COUNT fabric registers with byte strobes,
// per-register read-only status mapping and DECERR/SLVERR decode.
module axi4_lite_register_slave #(
    parameter int                     ADDR_WIDTH = 32,
    parameter int                     DATA_WIDTH = 32,
    parameter int                     REG_COUNT  = 16,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
    parameter logic [REG_COUNT-1:0]   RO_MASK    = '0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              awvalid,
    output logic                              awready,
    input  logic [ADDR_WIDTH-1:0]             awaddr,
    input  logic [2:0]                        awprot,
    input  logic                              wvalid,
    output logic                              wready,
    input  logic [DATA_WIDTH-1:0]             wdata,
    input  logic [DATA_WIDTH/8-1:0]           wstrb,
    output logic                              bvalid,
    input  logic                              bready,
    output logic [1:0]                        bresp,
    input  logic                              arvalid,
    output logic                              arready,
    input  logic [ADDR_WIDTH-1:0]             araddr,
    input  logic [2:0]                        arprot,
    output logic                              rvalid,
    input  logic                              rready,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic [1:0]                        rresp,
    output logic [REG_COUNT*DATA_WIDTH-1:0]   reg_q,
    output logic [REG_COUNT-1:0]              reg_wr,
    input  logic [REG_COUNT*DATA_WIDTH-1:0]   hw_status
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB_W = $clog2(BYTES);
    localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(REG_COUNT * BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    // Subtracting with one extra bit makes an address below BASE_ADDR wrap
    // to a huge offset, so a single range compare catches both DECERR cases.
    function automatic logic [1:0] decode_resp(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] diff;
        diff = {1'b0, addr} - {1'b0, BASE_ADDR};
        if (diff >= SPAN)
            return RESP_DECERR;
        if (addr[LSB_W-1:0] != '0)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] decode_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'(({1'b0, addr} - {1'b0, BASE_ADDR}) >> LSB_W);
    endfunction

    w_state_e                  w_state_q, w_state_d;
    r_state_e                  r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [BYTES-1:0]          wstrb_q, wstrb_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [REG_COUNT-1:0]      reg_wr_q, reg_wr_d;
    logic [DATA_WIDTH-1:0]     regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0]     regs_d [REG_COUNT];

    logic                      commit;
    logic [ADDR_WIDTH-1:0]     c_addr;
    logic [DATA_WIDTH-1:0]     c_data;
    logic [BYTES-1:0]          c_strb;
    logic [1:0]                c_resp;
    logic [IDX_W-1:0]          c_idx;
    logic [1:0]                r_resp;
    logic [IDX_W-1:0]          r_idx;
    logic                      aw_fire, w_fire, ar_fire;
    logic                      unused_prot;

    assign unused_prot = ^{awprot, arprot};

    assign awready = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_DATA);
    assign wready  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_ADDR);
    assign bvalid  = (w_state_q == W_RESP);
    assign bresp   = bresp_q;
    assign arready = (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_RESP);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign reg_wr  = reg_wr_q;
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign ar_fire = arvalid && arready;

    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg_out
        assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
    end

    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        reg_wr_d  = '0;
        commit    = 1'b0;
        c_addr    = awaddr_q;
        c_data    = wdata_q;
        c_strb    = wstrb_q;
        c_resp    = RESP_OKAY;
        c_idx     = '0;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_fire && w_fire) begin
                    commit = 1'b1;
                    c_addr = awaddr;
                    c_data = wdata;
                    c_strb = wstrb;
                end else if (aw_fire) begin
                    awaddr_d  = awaddr;
                    w_state_d = W_HAVE_ADDR;
                end else if (w_fire) begin
                    wdata_d   = wdata;
                    wstrb_d   = wstrb;
                    w_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_fire) begin
                    commit = 1'b1;
                    c_data = wdata;
                    c_strb = wstrb;
                end
            end
            W_HAVE_DATA: begin
                if (aw_fire) begin
                    commit = 1'b1;
                    c_addr = awaddr;
                end
            end
            W_RESP: begin
                if (bready)
                    w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase

        // Register update and reg_wr are launched together with the move to W_RESP.
        if (commit) begin
            c_resp = decode_resp(c_addr);
            c_idx  = decode_idx(c_addr);
            if (c_resp == RESP_OKAY && RO_MASK[c_idx])
                c_resp = RESP_SLVERR;
            if (c_resp == RESP_OKAY) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (c_strb[b])
                        regs_d[c_idx][b*8 +: 8] = c_data[b*8 +: 8];
                end
                reg_wr_d[c_idx] = 1'b1;
            end
            bresp_d   = c_resp;
            w_state_d = W_RESP;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        r_resp    = decode_resp(araddr);
        r_idx     = decode_idx(araddr);
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    // regs_q is the pre-write value, so a same-cycle write is not visible.
                    rdata_d = '0;
                    if (r_resp == RESP_OKAY)
                        rdata_d = RO_MASK[r_idx] ? hw_status[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH]
                                                 : regs_q[r_idx];
                    rresp_d   = r_resp;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (rready)
                    r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            reg_wr_q  <= '0;
            for (int i = 0; i < REG_COUNT; i++)
                regs_q[i] <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            reg_wr_q  <= reg_wr_d;
            for (int i = 0; i < REG_COUNT; i++)
                regs_q[i] <= regs_d[i];
        end
    end

endmodule

// File: tb/tb_axi4_lite_register_slave.sv
// Scoreboard bench for axi4_lite_register_slave: expected B/R responses are
// queued at issue time and compared when the slave returns them.
module tb_axi4_lite_register_slave;

    localparam int          AW = 32;
    localparam int          DW = 32;
    localparam int          NR = 16;
    localparam logic [15:0] RO = 16'h0008;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic            bready = 1'b1, rready = 1'b1;
    logic            awready, wready, bvalid, arready, rvalid;
    logic [AW-1:0]   awaddr = '0, araddr = '0;
    logic [2:0]      awprot = 3'b000, arprot = 3'b000;
    logic [DW-1:0]   wdata = '0;
    logic [3:0]      wstrb = '0;
    logic [1:0]      bresp, rresp;
    logic [DW-1:0]   rdata;
    logic [NR*DW-1:0] reg_q;
    logic [NR-1:0]   reg_wr;
    logic [NR*DW-1:0] hw_status;

    axi4_lite_register_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_COUNT(NR),
        .BASE_ADDR(32'h0), .RO_MASK(RO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .reg_q(reg_q), .reg_wr(reg_wr), .hw_status(hw_status)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] model [NR];
    int          exp_wr [NR];
    int          wr_cnt [NR];
    logic [1:0]  bq [$];
    logic [1:0]  rq_resp [$];
    logic [31:0] rq_data [$];

    function automatic logic [31:0] status_word(input int i);
        return (i == 3) ? 32'hCAFE0001 : (32'h5A000000 | 32'(i));
    endfunction

    initial begin
        for (int i = 0; i < NR; i++) begin
            hw_status[i*DW +: DW] = status_word(i);
            model[i]  = '0;
            exp_wr[i] = 0;
            wr_cnt[i] = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] a, input bit is_wr);
        if (a >= 32'(NR * 4)) return 2'b11;
        if (a[1:0] != 2'b00) return 2'b10;
        if (is_wr && RO[a[5:2]]) return 2'b10;
        return 2'b00;
    endfunction

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] r;
        int         i;
        r = exp_resp(a, 1'b1);
        i = int'(a[5:2]);
        bq.push_back(r);
        if (r == 2'b00) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[i][b*8 +: 8] = d[b*8 +: 8];
            exp_wr[i]++;
        end
    endtask

    task automatic expect_read(input logic [31:0] a);
        logic [1:0] r;
        int         i;
        r = exp_resp(a, 1'b0);
        i = int'(a[5:2]);
        rq_resp.push_back(r);
        rq_data.push_back((r != 2'b00) ? 32'h0 : (RO[i] ? status_word(i) : model[i]));
    endtask

    // Response monitor: compare on the falling edge of the accepting cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (bvalid && bready) begin
                if (bq.size() == 0) chk("b_unexpected", 1, 0);
                else chk("bresp", bresp, bq.pop_front());
            end
            if (rvalid && rready) begin
                if (rq_resp.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    chk("rresp", rresp, rq_resp.pop_front());
                    chk("rdata", rdata, rq_data.pop_front());
                end
            end
            for (int i = 0; i < NR; i++)
                if (reg_wr[i]) wr_cnt[i]++;
        end
    end

    task automatic send_aw(input logic [31:0] a);
        bit ok = 1'b0;
        awaddr = a; awvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        if (!ok) chk("aw_timeout", 0, 1);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 1'b0;
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        wvalid = 1'b0;
        if (!ok) chk("w_timeout", 0, 1);
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit ok = 1'b0;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (!ok) chk("ar_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && (bq.size() != 0 || rq_resp.size() != 0); i++)
            @(negedge clk);
        if (bq.size() != 0 || rq_resp.size() != 0) chk("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    // mode 0: AW+W together, 1: AW leads, 2: W leads by three cycles
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int mode);
        expect_write(a, d, s);
        case (mode)
            0: fork send_aw(a); send_w(d, s); join
            1: begin send_aw(a); @(posedge clk); #1; send_w(d, s); end
            default: begin
                send_w(d, s);
                @(negedge clk);
                chk("have_data_wready", wready, 0);
                chk("have_data_awready", awready, 1);
                repeat (2) @(posedge clk);
                #1;
                send_aw(a);
            end
        endcase
        chk("b_latency", bvalid, 1);
        wait_drain();
    endtask

    task automatic do_read(input logic [31:0] a);
        expect_read(a);
        send_ar(a);
        chk("r_latency", rvalid, 1);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          w2, w3;
        logic [31:0] a, d;
        logic [3:0]  s;

        // Reset values
        #12;
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_reg_wr", reg_wr, 0);
        chk("rst_reg_q", (reg_q == '0), 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Same-cycle AW/W full write
        w2 = exp_wr[2];
        do_write(32'h8, 32'hDEADBEEF, 4'hF, 0);
        chk("reg2_full", reg_q[2*DW +: DW], 32'hDEADBEEF);
        chk("reg2_wr_pulse", wr_cnt[2] - w2, 1);

        // W ahead of AW, single byte strobe
        do_write(32'h8, 32'h11223344, 4'hF, 1);
        do_write(32'h8, 32'h000000AA, 4'h1, 2);
        chk("reg2_strb", reg_q[2*DW +: DW], 32'h112233AA);

        // wstrb = 0: OKAY, no change, reg_wr still pulses
        w2 = exp_wr[2];
        do_write(32'h8, 32'hFFFFFFFF, 4'h0, 0);
        chk("reg2_nostrb", reg_q[2*DW +: DW], 32'h112233AA);
        chk("reg2_nostrb_wr", wr_cnt[2] - w2, 1);

        // Decode errors
        do_read(32'h40);
        do_write(32'h9, 32'h55555555, 4'hF, 0);
        do_write(32'h44, 32'h66666666, 4'hF, 1);
        chk("reg2_after_err", reg_q[2*DW +: DW], 32'h112233AA);

        // Read-only register
        w3 = wr_cnt[3];
        do_write(32'hC, 32'hFFFFFFFF, 4'hF, 0);
        chk("ro_no_wr", wr_cnt[3] - w3, 0);
        chk("ro_reg_q", reg_q[3*DW +: DW], 32'h0);
        do_read(32'hC);

        // Back-pressure with simultaneous write/read of the same register
        do_write(32'h14, 32'h01020304, 4'hF, 0);
        bready = 1'b0; rready = 1'b0;
        expect_read(32'h14);
        expect_write(32'h14, 32'hA5A5A5A5, 4'hF);
        fork send_aw(32'h14); send_w(32'hA5A5A5A5, 4'hF); send_ar(32'h14); join
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_bvalid", bvalid, 1);
            chk("hold_rvalid", rvalid, 1);
            chk("hold_bresp", bresp, 0);
            chk("hold_rdata", rdata, 32'h01020304);
            chk("hold_ready", {awready, wready, arready}, 3'b000);
        end
        @(posedge clk); #1;
        bready = 1'b1; rready = 1'b1;
        wait_drain();
        chk("reg5_new", reg_q[5*DW +: DW], 32'hA5A5A5A5);

        // Mixed traffic with read-back
        for (int k = 0; k < 18; k++) begin
            a = 32'($urandom_range(0, 7)) << 2;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            do_write(a, d, s, k % 3);
            do_read((k % 4 == 3) ? (a | 32'h2) : a);
        end
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("final_reg%0d", i), reg_q[i*DW +: DW], model[i]);
            chk($sformatf("final_wr%0d", i), wr_cnt[i], exp_wr[i]);
        end

        // Reset while holding an address in W_HAVE_ADDR
        send_aw(32'h8);
        chk("have_addr_awready", awready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_bvalid", bvalid, 0);
        chk("midrst_awready", awready, 1);
        chk("midrst_wready", wready, 1);
        chk("midrst_reg_q", (reg_q == '0), 1);
        for (int i = 0; i < NR; i++) model[i] = '0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(32'h8);
        do_write(32'h4, 32'h0BADF00D, 4'hF, 2);
        do_read(32'h4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
